// File: rtl/runway_pkg.sv
// Shared scheduler state encoding and default sizing for the runway scheduler.
package runway_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LANDING = 2'd1,
    S_TAKEOFF = 2'd2
  } sched_state_t;

  localparam int DEF_QUEUE_DEPTH     = 4;
  localparam int DEF_ID_W            = 4;
  localparam int DEF_LAND_CYCLES     = 5;
  localparam int DEF_TAKEOFF_CYCLES  = 3;
  localparam int DEF_MAX_CONSEC_LAND = 3;

endpackage

// File: rtl/runway_queue.sv
// Synchronous FIFO for flight requests; push is dropped when full, pop ignored when empty.
module runway_queue
  import runway_pkg::*;
#(
  parameter int DEPTH = DEF_QUEUE_DEPTH,
  parameter int W     = DEF_ID_W
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    push,
  input  logic                    pop,
  input  logic                    flush,
  input  logic [W-1:0]            din,
  output logic [W-1:0]            dout,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_r [DEPTH];
  logic [AW-1:0] rd_ptr_r;
  logic [AW-1:0] wr_ptr_r;
  logic [AW:0]   count_r;
  logic          do_push_s;
  logic          do_pop_s;

  assign full      = (count_r == (AW+1)'(DEPTH));
  assign empty     = (count_r == {(AW+1){1'b0}});
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;
  assign dout      = mem_r[rd_ptr_r];
  assign count     = count_r;

  // Pointer and occupancy bookkeeping; flush discards everything, including a same-edge push.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_ptr_r <= {AW{1'b0}};
      wr_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else if (flush) begin
      rd_ptr_r <= {AW{1'b0}};
      wr_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage.
  always_ff @(posedge CLK) begin
    if (do_push_s && !flush) mem_r[wr_ptr_r] <= din;
  end

endmodule

// File: rtl/runway_scheduler.sv
// Arbitrates the single runway between landing and takeoff queues with weather/emergency gating.
module runway_scheduler
  import runway_pkg::*;
#(
  parameter int QUEUE_DEPTH     = DEF_QUEUE_DEPTH,
  parameter int ID_W            = DEF_ID_W,
  parameter int LAND_CYCLES     = DEF_LAND_CYCLES,
  parameter int TAKEOFF_CYCLES  = DEF_TAKEOFF_CYCLES,
  parameter int MAX_CONSEC_LAND = DEF_MAX_CONSEC_LAND
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         severe_weather,
  input  logic                         emergency_landing_alert,
  input  logic                         land_req,
  input  logic [ID_W-1:0]              land_id,
  input  logic                         takeoff_req,
  input  logic [ID_W-1:0]              takeoff_id,
  output logic                         land_accepted,
  output logic                         land_rejected,
  output logic                         takeoff_accepted,
  output logic                         takeoff_rejected,
  output logic                         grant_valid,
  output logic [ID_W-1:0]              grant_id,
  output logic                         grant_is_landing,
  output logic                         runway_busy,
  output logic [1:0]                   sched_state,
  output logic                         emergency_mode,
  output logic [$clog2(QUEUE_DEPTH):0] land_count,
  output logic [$clog2(QUEUE_DEPTH):0] takeoff_count
);

  localparam int MAX_OCC = (LAND_CYCLES > TAKEOFF_CYCLES) ? LAND_CYCLES : TAKEOFF_CYCLES;
  localparam int TW      = $clog2(MAX_OCC + 1);
  localparam int CLW     = $clog2(MAX_CONSEC_LAND + 1);

  sched_state_t    state_r, state_n;
  logic [TW-1:0]   timer_r, timer_n;
  logic [CLW-1:0]  consec_r, consec_n;
  logic            emergency_mode_r;
  logic            land_accepted_r, land_rejected_r;
  logic            takeoff_accepted_r, takeoff_rejected_r;
  logic            grant_valid_r, grant_is_landing_r, runway_busy_r;
  logic [ID_W-1:0] grant_id_r;

  logic            grant_land_s, grant_to_s, to_ok_s, to_push_s;
  logic            land_full_s, land_empty_s, to_full_s, to_empty_s;
  logic [ID_W-1:0] land_head_s, to_head_s;

  // A takeoff request racing an emergency alert is refused, matching the same-edge flush.
  assign to_push_s = takeoff_req && !to_full_s && !emergency_mode_r && !emergency_landing_alert;
  assign to_ok_s   = !to_empty_s && !emergency_mode_r && !emergency_landing_alert && !severe_weather;

  runway_queue #(.DEPTH(QUEUE_DEPTH), .W(ID_W)) u_land_q (
    .CLK(CLK), .RST(RST), .push(land_req), .pop(grant_land_s), .flush(1'b0),
    .din(land_id), .dout(land_head_s), .count(land_count),
    .full(land_full_s), .empty(land_empty_s)
  );

  runway_queue #(.DEPTH(QUEUE_DEPTH), .W(ID_W)) u_takeoff_q (
    .CLK(CLK), .RST(RST), .push(to_push_s), .pop(grant_to_s), .flush(emergency_landing_alert),
    .din(takeoff_id), .dout(to_head_s), .count(takeoff_count),
    .full(to_full_s), .empty(to_empty_s)
  );

  // Arbitration, occupancy timer and consecutive-landing tracking.
  always_comb begin
    state_n      = state_r;
    timer_n      = timer_r;
    consec_n     = consec_r;
    grant_land_s = 1'b0;
    grant_to_s   = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (to_ok_s && (consec_r == CLW'(MAX_CONSEC_LAND))) begin
          grant_to_s = 1'b1;
          state_n    = S_TAKEOFF;
          timer_n    = TW'(TAKEOFF_CYCLES - 1);
          consec_n   = {CLW{1'b0}};
        end else if (!land_empty_s) begin
          grant_land_s = 1'b1;
          state_n      = S_LANDING;
          timer_n      = TW'(LAND_CYCLES - 1);
          if (to_empty_s) begin
            consec_n = {CLW{1'b0}};
          end else if (consec_r == CLW'(MAX_CONSEC_LAND)) begin
            consec_n = consec_r;
          end else begin
            consec_n = consec_r + CLW'(1);
          end
        end else if (to_ok_s) begin
          grant_to_s = 1'b1;
          state_n    = S_TAKEOFF;
          timer_n    = TW'(TAKEOFF_CYCLES - 1);
          consec_n   = {CLW{1'b0}};
        end else begin
          state_n = S_IDLE;
        end
      end
      S_LANDING, S_TAKEOFF: begin
        if (timer_r == {TW{1'b0}}) begin
          state_n = S_IDLE;
        end else begin
          timer_n = timer_r - TW'(1);
        end
      end
      default: begin
        state_n = S_IDLE;
        timer_n = {TW{1'b0}};
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r            <= S_IDLE;
      timer_r            <= {TW{1'b0}};
      consec_r           <= {CLW{1'b0}};
      emergency_mode_r   <= 1'b0;
      land_accepted_r    <= 1'b0;
      land_rejected_r    <= 1'b0;
      takeoff_accepted_r <= 1'b0;
      takeoff_rejected_r <= 1'b0;
      grant_valid_r      <= 1'b0;
      grant_id_r         <= {ID_W{1'b0}};
      grant_is_landing_r <= 1'b0;
      runway_busy_r      <= 1'b0;
    end else begin
      state_r            <= state_n;
      timer_r            <= timer_n;
      consec_r           <= consec_n;
      emergency_mode_r   <= emergency_mode_r | emergency_landing_alert;
      land_accepted_r    <= land_req && !land_full_s;
      land_rejected_r    <= land_req && land_full_s;
      takeoff_accepted_r <= to_push_s;
      takeoff_rejected_r <= takeoff_req && !to_push_s;
      grant_valid_r      <= grant_land_s || grant_to_s;
      runway_busy_r      <= (state_n != S_IDLE);
      if (grant_land_s) begin
        grant_id_r         <= land_head_s;
        grant_is_landing_r <= 1'b1;
      end else if (grant_to_s) begin
        grant_id_r         <= to_head_s;
        grant_is_landing_r <= 1'b0;
      end
    end
  end

  assign land_accepted    = land_accepted_r;
  assign land_rejected    = land_rejected_r;
  assign takeoff_accepted = takeoff_accepted_r;
  assign takeoff_rejected = takeoff_rejected_r;
  assign grant_valid      = grant_valid_r;
  assign grant_id         = grant_id_r;
  assign grant_is_landing = grant_is_landing_r;
  assign runway_busy      = runway_busy_r;
  assign sched_state      = state_r;
  assign emergency_mode   = emergency_mode_r;

endmodule

// File: tb/tb_runway_scheduler.sv
// Directed self-checking bench for runway_scheduler with hand-computed expectations.
module tb_runway_scheduler;

  logic       CLK = 1'b0;
  logic       RST;
  logic       severe_weather, emergency_landing_alert;
  logic       land_req, takeoff_req;
  logic [3:0] land_id, takeoff_id;
  logic       land_accepted, land_rejected, takeoff_accepted, takeoff_rejected;
  logic       grant_valid, grant_is_landing, runway_busy, emergency_mode;
  logic [3:0] grant_id;
  logic [1:0] sched_state;
  logic [2:0] land_count, takeoff_count;

  int n_checks = 0;
  int n_fail   = 0;
  logic [4:0] grant_log[$];

  always #5 CLK = ~CLK;

  runway_scheduler dut (
    .CLK(CLK), .RST(RST),
    .severe_weather(severe_weather), .emergency_landing_alert(emergency_landing_alert),
    .land_req(land_req), .land_id(land_id),
    .takeoff_req(takeoff_req), .takeoff_id(takeoff_id),
    .land_accepted(land_accepted), .land_rejected(land_rejected),
    .takeoff_accepted(takeoff_accepted), .takeoff_rejected(takeoff_rejected),
    .grant_valid(grant_valid), .grant_id(grant_id), .grant_is_landing(grant_is_landing),
    .runway_busy(runway_busy), .sched_state(sched_state), .emergency_mode(emergency_mode),
    .land_count(land_count), .takeoff_count(takeoff_count)
  );

  // Record every grant as {is_landing, id}.
  always @(negedge CLK) begin
    if (grant_valid) grant_log.push_back({grant_is_landing, grant_id});
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_land(input logic [3:0] id);
    land_req = 1'b1;
    land_id  = id;
    tick();
    land_req = 1'b0;
  endtask

  task automatic push_to(input logic [3:0] id);
    takeoff_req = 1'b1;
    takeoff_id  = id;
    tick();
    takeoff_req = 1'b0;
  endtask

  task automatic wait_grant(input string tag);
    for (int i = 0; i < 100 && !grant_valid; i++) tick();
    check(tag, grant_valid, 1);
  endtask

  task automatic count_busy(output int n);
    n = 0;
    for (int i = 0; i < 50 && runway_busy; i++) begin
      n++;
      tick();
    end
  endtask

  task automatic wait_log(input string tag, input int n);
    for (int i = 0; i < 300 && grant_log.size() < n; i++) tick();
    check(tag, grant_log.size(), n);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 50 && runway_busy; i++) tick();
  endtask

  int busy_n;
  int seen;
  logic [4:0] exp_order [5];

  initial begin
    RST = 1'b1; severe_weather = 1'b0; emergency_landing_alert = 1'b0;
    land_req = 1'b0; takeoff_req = 1'b0; land_id = 4'd0; takeoff_id = 4'd0;
    tick(); tick();
    check("rst_flags", {land_accepted, land_rejected, takeoff_accepted, takeoff_rejected,
                        grant_valid, grant_is_landing, runway_busy, emergency_mode}, 0);
    check("rst_state", {grant_id, sched_state, land_count, takeoff_count}, 0);
    RST = 1'b0;

    // Single landing: accept, grant, 5 busy cycles, back to idle.
    push_land(4'd3);
    check("t1_accept", {land_accepted, land_rejected}, 2'b10);
    wait_grant("t1_grant");
    check("t1_id", {grant_is_landing, grant_id}, {1'b1, 4'd3});
    count_busy(busy_n);
    check("t1_busy", busy_n, 5);
    check("t1_idle", sched_state, 0);
    check("t1_hold", grant_id, 3);

    // Fill the landing queue while the runway is occupied; fifth request hits full.
    grant_log.delete();
    push_land(4'd10);
    tick();
    for (int i = 1; i <= 4; i++) begin
      push_land(4'(i));
      check("t2_accept", {land_accepted, land_rejected}, 2'b10);
    end
    check("t2_full", land_count, 4);
    push_land(4'd5);
    check("t2_reject", {land_accepted, land_rejected}, 2'b01);
    wait_log("t2_ngrants", 5);
    for (int i = 0; i < 5 && i < grant_log.size(); i++)
      check("t2_order", grant_log[i], (i == 0) ? 5'h1a : {1'b1, 4'(i)});
    wait_idle();

    // Fairness: after three landings a pending takeoff is forced in.
    grant_log.delete();
    land_req = 1'b1; land_id = 4'd1; takeoff_req = 1'b1; takeoff_id = 4'd9;
    tick();
    takeoff_req = 1'b0; land_req = 1'b0;
    check("t3_to_accept", takeoff_accepted, 1);
    push_land(4'd2);
    push_land(4'd3);
    push_land(4'd4);
    exp_order = '{5'h11, 5'h12, 5'h13, 5'h09, 5'h14};
    wait_log("t3_ngrants", 5);
    for (int i = 0; i < 5 && i < grant_log.size(); i++)
      check("t3_order", grant_log[i], exp_order[i]);
    wait_idle();

    // Severe weather holds takeoffs until it clears.
    severe_weather = 1'b1;
    push_to(4'd7);
    check("t4_accept", takeoff_accepted, 1);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (grant_valid) seen++;
      tick();
    end
    check("t4_no_grant", seen, 0);
    check("t4_count", takeoff_count, 1);
    severe_weather = 1'b0;
    wait_grant("t4_grant");
    check("t4_id", {grant_is_landing, grant_id}, {1'b0, 4'd7});
    count_busy(busy_n);
    check("t4_busy", busy_n, 3);

    // Emergency during a takeoff: flush, finish the takeoff, refuse new takeoffs.
    push_to(4'd2);
    takeoff_req = 1'b1; takeoff_id = 4'd10;
    tick();
    check("t5_grant", {grant_valid, grant_is_landing, grant_id}, {1'b1, 1'b0, 4'd2});
    takeoff_id = 4'd11;
    tick();
    takeoff_req = 1'b0;
    check("t5_qcount", takeoff_count, 2);
    emergency_landing_alert = 1'b1;
    tick();
    emergency_landing_alert = 1'b0;
    check("t5_flush", {emergency_mode, takeoff_count}, {1'b1, 3'd0});
    check("t5_busy3", runway_busy, 1);
    tick();
    check("t5_done", {runway_busy, sched_state}, 3'b000);
    push_to(4'd12);
    check("t5_reject", {takeoff_accepted, takeoff_rejected}, 2'b01);
    push_land(4'd6);
    wait_grant("t5_lgrant");
    check("t5_lid", {grant_is_landing, grant_id}, {1'b1, 4'd6});

    // Reset mid-occupancy aborts everything.
    push_land(4'd8);
    check("t6_queued", land_count, 1);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("t6_flags", {land_accepted, land_rejected, takeoff_accepted, takeoff_rejected,
                       grant_valid, grant_is_landing, runway_busy, emergency_mode}, 0);
    check("t6_state", {grant_id, sched_state, land_count, takeoff_count}, 0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (grant_valid || runway_busy) seen++;
    end
    check("t6_quiet", seen, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
